// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, register-zero
// constant and bit positions of the packed control-output bundle.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned CtlPcHold      = 0;
  localparam int unsigned CtlIfidHold    = 1;
  localparam int unsigned CtlIfidFlush   = 2;
  localparam int unsigned CtlIdexBubble  = 3;
  localparam int unsigned CtlIdexHold    = 4;
  localparam int unsigned CtlExmemHold   = 5;
  localparam int unsigned CtlMemwbBubble = 6;
  localparam int unsigned CtlWidth       = 7;

  // Whole-pipe freeze while data memory is outstanding.
  localparam logic [CtlWidth-1:0] CtlFreeze = (7'd1 << CtlPcHold) | (7'd1 << CtlIfidHold) |
                                              (7'd1 << CtlIdexHold) | (7'd1 << CtlExmemHold) |
                                              (7'd1 << CtlMemwbBubble);
  localparam logic [CtlWidth-1:0] CtlBranch = (7'd1 << CtlIfidFlush) | (7'd1 << CtlIdexBubble);
  localparam logic [CtlWidth-1:0] CtlFlush  = (7'd1 << CtlIfidFlush);
  localparam logic [CtlWidth-1:0] CtlStall  = (7'd1 << CtlPcHold) | (7'd1 << CtlIfidHold) |
                                              (7'd1 << CtlIdexBubble);

endpackage

// File: rtl/load_use_cmp.sv
// Combinational load-use detector: a load in EX writes a register the ID
// instruction reads. Shared with the forwarding unit.
module load_use_cmp
  import hazard_pkg::*;
(
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  output logic       o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_rt == i_id_rs);
  assign w_rt_match = i_id_uses_rt & (i_ex_rt == i_id_rt);
  // $zero is never a real dependency.
  assign o_load_use = i_ex_memread & (i_ex_rt != REG_ZERO) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze > taken-branch flush > load-use stall.
// Optional HAZARD_PERF_EN adds saturating stall/flush/wait performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        memwb_bubble,
  output logic        mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] wait_cycles
`endif
);

  localparam logic [1:0] FlushReload = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TimeoutCnt  = 8'(MEM_TIMEOUT);

  hz_state_e             r_state, w_state_d;
  logic [1:0]            r_flush_cnt, w_flush_cnt_d;
  logic [7:0]            r_wait_cnt, w_wait_cnt_d;
  logic                  r_br_pend, w_br_pend_d;
  logic                  r_mem_err, w_mem_err_d;
  logic [CtlWidth-1:0]   w_ctl;
  logic                  w_load_use;
  logic                  w_mem_stall;

  load_use_cmp u_load_use_cmp (
    .i_ex_memread (ex_memread),
    .i_ex_rt      (ex_rt),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rt (id_uses_rt),
    .o_load_use   (w_load_use)
  );

  assign w_mem_stall = mem_req & ~mem_ready;

  always_comb begin
    w_ctl         = '0;
    w_state_d     = r_state;
    w_flush_cnt_d = r_flush_cnt;
    w_wait_cnt_d  = r_wait_cnt;
    w_br_pend_d   = r_br_pend;
    w_mem_err_d   = r_mem_err;
    unique case (r_state)
      StRun: begin
        if (w_mem_stall) begin
          w_ctl        = CtlFreeze;
          w_state_d    = StMemWait;
          w_wait_cnt_d = 8'd1;
          w_br_pend_d  = branch_taken;
        end else if (branch_taken) begin
          w_ctl = CtlBranch;
          if (FLUSH_CYCLES > 1) begin
            w_state_d     = StFlush;
            w_flush_cnt_d = FlushReload;
          end
        end else if (w_load_use) begin
          w_ctl = CtlStall;
        end
      end
      StMemWait: begin
        if (branch_taken) w_br_pend_d = 1'b1;
        if (mem_ready) begin
          w_state_d    = StRun;
          w_wait_cnt_d = 8'd0;
          // A branch seen during the wait is flushed as the freeze lifts.
          if (r_br_pend || branch_taken) begin
            w_ctl       = CtlBranch;
            w_br_pend_d = 1'b0;
            if (FLUSH_CYCLES > 1) begin
              w_state_d     = StFlush;
              w_flush_cnt_d = FlushReload;
            end
          end
        end else if (r_wait_cnt == TimeoutCnt) begin
          w_mem_err_d  = 1'b1;
          w_state_d    = StRun;
          w_wait_cnt_d = 8'd0;
          w_br_pend_d  = 1'b0;
        end else begin
          w_ctl        = CtlFreeze;
          w_wait_cnt_d = r_wait_cnt + 8'd1;
        end
      end
      StFlush: begin
        if (w_mem_stall) begin
          // Restart the whole flush once memory completes.
          w_ctl         = CtlFreeze;
          w_state_d     = StMemWait;
          w_wait_cnt_d  = 8'd1;
          w_br_pend_d   = 1'b1;
          w_flush_cnt_d = 2'd0;
        end else if (branch_taken) begin
          w_ctl         = CtlBranch;
          w_flush_cnt_d = FlushReload;
          if (FlushReload == 2'd0) w_state_d = StRun;
        end else begin
          w_ctl = CtlFlush;
          if (r_flush_cnt <= 2'd1) begin
            w_flush_cnt_d = 2'd0;
            w_state_d     = StRun;
          end else begin
            w_flush_cnt_d = r_flush_cnt - 2'd1;
          end
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StRun;
      r_flush_cnt <= 2'd0;
      r_wait_cnt  <= 8'd0;
      r_br_pend   <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_flush_cnt <= w_flush_cnt_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_br_pend   <= w_br_pend_d;
      r_mem_err   <= w_mem_err_d;
    end
  end

  assign pc_hold      = rst_n & w_ctl[CtlPcHold];
  assign ifid_hold    = rst_n & w_ctl[CtlIfidHold];
  assign ifid_flush   = rst_n & w_ctl[CtlIfidFlush];
  assign idex_bubble  = rst_n & w_ctl[CtlIdexBubble];
  assign idex_hold    = rst_n & w_ctl[CtlIdexHold];
  assign exmem_hold   = rst_n & w_ctl[CtlExmemHold];
  assign memwb_bubble = rst_n & w_ctl[CtlMemwbBubble];
  assign mem_err      = r_mem_err;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles, r_flush_events, r_wait_cycles;
  logic        w_stall_inc;

  assign w_stall_inc = (r_state == StRun) & ~w_mem_stall & ~branch_taken & w_load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'd0;
      r_flush_events <= 32'd0;
      r_wait_cycles  <= 32'd0;
    end else begin
      if (w_stall_inc && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (branch_taken && r_flush_events != '1) r_flush_events <= r_flush_events + 32'd1;
      if (r_state == StMemWait && r_wait_cycles != '1) r_wait_cycles <= r_wait_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
  assign wait_cycles  = r_wait_cycles;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control end of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Observes register fields, branch resolution and the data-memory handshake, and drives the hold, flush and bubble controls back into those registers and the PC.
- Resolves three hazard classes with fixed priority: memory wait, taken-branch flush, load-use stall.
- FSM state and counters are registered; control outputs are a combinational decode of state plus inputs.

Parameters:
- FLUSH_CYCLES, 1, number of cycles IF/ID is flushed per taken branch (1..4).
- MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort (1..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the IF/ID instruction.
- id_rt  in  5  rt field of the IF/ID instruction.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_memread  in  1  MemRead bit of ID/EX.
- ex_rt  in  5  rt (load destination) field of ID/EX.
- branch_taken  in  1  PCsrc, taken branch or jump resolved this cycle.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps contents (IFtoIDWrite polarity: 1 = hold).
- ifid_flush  out  1  IF/ID loads zero.
- idex_bubble  out  1  ID/EX control fields are loaded as zero.
- idex_hold  out  1  ID/EX keeps contents.
- exmem_hold  out  1  EX/MEM keeps contents.
- memwb_bubble  out  1  MEM/WB RegWrite is loaded as zero.
- mem_err  out  1  sticky flag, memory timeout occurred.

Behaviour:
- Reset: state=RUN; flush_cnt=0; wait_cnt=0; br_pend=0; mem_err=0. All control outputs are 0 while rst_n=0.
- load_use = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- RUN state, checked in priority order:
  - mem_req & !mem_ready: assert pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_bubble. Next state MEM_WAIT, wait_cnt=1. Also set br_pend if branch_taken is high this cycle.
  - Else branch_taken: assert ifid_flush and idex_bubble. If FLUSH_CYCLES>1, next state FLUSH with flush_cnt=FLUSH_CYCLES-1.
  - Else load_use: assert pc_hold, ifid_hold and idex_bubble for exactly 1 cycle. The hazard clears on the next edge once the bubble reaches ID/EX.
  - Else all outputs are 0.
- MEM_WAIT state:
  - Full freeze (same five outputs as above).
  - branch_taken during wait sets br_pend.
  - mem_ready=1: freeze is released in that same cycle (outputs 0 except flush handling). Next state RUN. If br_pend, assert ifid_flush+idex_bubble this cycle, clear br_pend and enter FLUSH if FLUSH_CYCLES>1.
  - wait_cnt==MEM_TIMEOUT and !mem_ready: set mem_err (sticky until reset), release freeze, go to RUN, clear br_pend.
  - Otherwise wait_cnt increments; it is 8 bits and does not wrap because the timeout comes first.
- FLUSH state:
  - Assert ifid_flush. Decrement flush_cnt; go to RUN when it reaches 0.
  - A new branch_taken reloads flush_cnt=FLUSH_CYCLES-1.
  - load_use is masked here because the ID instruction is being flushed.
  - mem_req & !mem_ready preempts: go to MEM_WAIT and set br_pend so the remaining flush reissues after the wait.
- Simultaneous events: mem wait > branch > load-use. hold and flush are never both asserted on IF/ID; flush wins only outside a freeze.
- Reset mid-operation: immediate return to RUN with outputs 0. Pending branches and counters are discarded.

Optional Feature:
- HAZARD_PERF_EN defined: adds 32-bit saturating output ports stall_cycles (load-use stalls), flush_events (taken branches accepted) and wait_cycles (cycles spent in MEM_WAIT). All reset to 0.
- Undefined: these ports and counters are absent; control behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - state encoding RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2;
  - REG_ZERO=5'd0;
  - output bundle bit positions.
- One sub-module, load_use_cmp: purely combinational load_use compare. Kept separate so the forwarding unit can reuse it.

Test Plan:
- lw into $8 (ex_memread=1, ex_rt=8), then add with id_rs=8 -> pc_hold=ifid_hold=idex_bubble=1 for exactly 1 cycle, then 0. With ex_rt=0 -> no stall.
- branch_taken pulse, FLUSH_CYCLES=3 -> ifid_flush high for 3 consecutive cycles, idex_bubble high only in the first.
- mem_req=1, mem_ready low for 4 cycles then high -> 4 frozen cycles, freeze released in the mem_ready cycle, mem_err=0.
- mem_ready never asserted, MEM_TIMEOUT=15 -> freeze released after 15 wait cycles, mem_err=1 and stays 1 until rst_n=0.
- branch_taken and load_use in the same cycle -> flush only, no stall. branch_taken during MEM_WAIT -> flush issued in the mem_ready cycle.
- rst_n dropped while in MEM_WAIT with wait_cnt=7 -> outputs 0 immediately; after release, state RUN and no pending flush.
